// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the stall/flush sequencer.
// Latency: none; this is a plain signal bundle.
// Backpressure: none; the sequencer backpressures the pipeline through the register enables.
//
// Ports (datapath -> sequencer): id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd,
//   ex_mem_read, ex_branch_taken, mem_req, dmem_ready
// Ports (sequencer -> datapath): pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
//   ex_mem_en, mem_wb_flush, dmem_valid, mem_err, stall_cycles, busy
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             dmem_ready;

    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_flush;
    logic             ex_mem_en;
    logic             mem_wb_flush;
    logic             dmem_valid;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;
    logic             busy;

    // Pipeline / datapath side.
    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd,
               ex_mem_read, ex_branch_taken, mem_req, dmem_ready,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_en, mem_wb_flush, dmem_valid, mem_err, stall_cycles, busy
    );

    // Hazard sequencer side.
    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd,
               ex_mem_read, ex_branch_taken, mem_req, dmem_ready,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_en, mem_wb_flush, dmem_valid, mem_err, stall_cycles, busy
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait FSM, load-use and branch arbitration.
// Latency: control outputs are combinational from state and inputs; state and counters update on the next edge.
// Backpressure: a pending data-memory access freezes PC..EX/MEM and bubbles MEM/WB until ready or timeout.
//
// Ports: clk, reset (async active-high), hz (slave modport of pipeline_hazard_ctrl_if carrying
//   ID/EX/MEM hazard inputs and the enable/flush/dmem_valid/mem_err/stall_cycles/busy outputs).
module pipeline_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  hz
);

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    localparam int unsigned     WC_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit              WDOG_EN = (TIMEOUT != 0);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [0:0]       state_q, state_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_q;

    logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic ex_mem_en, mem_wb_flush, dmem_valid, busy;
    logic load_use, timeout_hit, mem_stall;

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                      ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

    assign timeout_hit = WDOG_EN && (wait_cnt_q == WC_LAST);

    // In MEM_WAIT the request stays asserted regardless of mem_req, since EX/MEM is frozen.
    assign mem_stall = (state_q == ST_RUN) ? (hz.mem_req && !hz.dmem_ready)
                                           : (!hz.dmem_ready && !timeout_hit);

    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_flush = 1'b0;
        dmem_valid   = 1'b0;
        busy         = 1'b0;
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        mem_err_d    = mem_err_q;

        if (!reset) begin
            busy       = (state_q == ST_MEM_WAIT);
            dmem_valid = (state_q == ST_RUN) ? hz.mem_req : 1'b1;

            if (mem_stall) begin
                // Freeze everything upstream of MEM; MEM/WB keeps clocking so it takes a bubble.
                mem_wb_flush = 1'b1;
                state_d      = ST_MEM_WAIT;
                wait_cnt_d   = (state_q == ST_RUN) ? '0 : wait_cnt_q + WC_W'(1);
            end else begin
                ex_mem_en = 1'b1;
                state_d   = ST_RUN;
                // Leaving MEM_WAIT without ready means the watchdog aborted the access.
                if ((state_q == ST_MEM_WAIT) && !hz.dmem_ready) begin
                    mem_err_d = 1'b1;
                end

                if (hz.ex_branch_taken) begin
                    // Branch squashes the ID instruction, so any load-use on it is moot.
                    pc_en       = 1'b1;
                    if_id_en    = 1'b1;
                    id_ex_en    = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    id_ex_en    = 1'b1;
                    id_ex_flush = 1'b1;
                end else begin
                    pc_en    = 1'b1;
                    if_id_en = 1'b1;
                    id_ex_en = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
            if (!pc_en && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign hz.pc_en        = pc_en;
    assign hz.if_id_en     = if_id_en;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_en     = id_ex_en;
    assign hz.id_ex_flush  = id_ex_flush;
    assign hz.ex_mem_en    = ex_mem_en;
    assign hz.mem_wb_flush = mem_wb_flush;
    assign hz.dmem_valid   = dmem_valid;
    assign hz.busy         = busy;
    assign hz.mem_err      = mem_err_q;
    assign hz.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a short watchdog and a narrow stall counter.
// Latency: checks combinational controls mid-cycle, registered state one edge later.
// Backpressure: n/a.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CNT_W = 4;

    // Control vector: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
    //                  ex_mem_en, mem_wb_flush, dmem_valid, busy}
    localparam logic [8:0] C_ZERO  = 9'b000000000;
    localparam logic [8:0] C_NORM  = 9'b110101000;
    localparam logic [8:0] C_LU    = 9'b000111000;
    localparam logic [8:0] C_BR    = 9'b111111000;
    localparam logic [8:0] C_MSRUN = 9'b000000110;
    localparam logic [8:0] C_MSWT  = 9'b000000111;
    localparam logic [8:0] C_BRWT  = 9'b111111011;
    localparam logic [8:0] C_DNWT  = 9'b110101011;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(
        .TIMEOUT(4),
        .CNT_W  (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .hz   (bus)
    );

    logic [8:0] ctl;
    assign ctl = {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_en, bus.id_ex_flush,
                  bus.ex_mem_en, bus.mem_wb_flush, bus.dmem_valid, bus.busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.id_rs1          = 5'd0;
        bus.id_rs2          = 5'd0;
        bus.id_uses_rs1     = 1'b0;
        bus.id_uses_rs2     = 1'b0;
        bus.ex_rd           = 5'd0;
        bus.ex_mem_read     = 1'b0;
        bus.ex_branch_taken = 1'b0;
        bus.mem_req         = 1'b0;
        bus.dmem_ready      = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        bus.ex_mem_read = 1'b1;
        bus.ex_rd       = rd;
        bus.id_rs2      = rd;
        bus.id_uses_rs2 = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        clear_inputs();

        // Reset state
        #3;
        check("rst_ctl", 32'(ctl), 32'(C_ZERO));
        check("rst_err", 32'(bus.mem_err), 32'd0);
        check("rst_cnt", 32'(bus.stall_cycles), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("run_ctl", 32'(ctl), 32'(C_NORM));

        // Async reset asserted mid-cycle, then released
        reset = 1'b1;
        #1;
        check("midrst_ctl", 32'(ctl), 32'(C_ZERO));
        tick();
        reset = 1'b0;
        #1;
        check("rel_ctl", 32'(ctl), 32'(C_NORM));
        check("rel_cnt", 32'(bus.stall_cycles), 32'd0);

        // Load-use on rs2 = x5: one stall cycle
        set_load_use(5'd5);
        #1;
        check("lu_ctl", 32'(ctl), 32'(C_LU));
        tick();
        clear_inputs();
        #1;
        check("lu_after_ctl", 32'(ctl), 32'(C_NORM));
        check("lu_cnt", 32'(bus.stall_cycles), 32'd1);

        // Load to x0: no hazard
        set_load_use(5'd0);
        #1;
        check("x0_ctl", 32'(ctl), 32'(C_NORM));
        tick();
        check("x0_cnt", 32'(bus.stall_cycles), 32'd1);
        clear_inputs();

        // rs1 matches but is not read: no hazard
        bus.ex_mem_read = 1'b1;
        bus.ex_rd       = 5'd7;
        bus.id_rs1      = 5'd7;
        bus.id_uses_rs1 = 1'b0;
        #1;
        check("rs1_unused_ctl", 32'(ctl), 32'(C_NORM));
        bus.id_uses_rs1 = 1'b1;
        #1;
        check("rs1_used_ctl", 32'(ctl), 32'(C_LU));
        clear_inputs();
        #1;

        // Branch and load-use together: branch wins, no stall
        set_load_use(5'd9);
        bus.ex_branch_taken = 1'b1;
        #1;
        check("br_lu_ctl", 32'(ctl), 32'(C_BR));
        tick();
        check("br_lu_cnt", 32'(bus.stall_cycles), 32'd1);
        clear_inputs();

        // Memory wait of 3 cycles with a taken branch held stable in EX
        bus.mem_req         = 1'b1;
        bus.dmem_ready      = 1'b0;
        bus.ex_branch_taken = 1'b1;
        #1;
        check("mw_c1_ctl", 32'(ctl), 32'(C_MSRUN));
        tick();
        check("mw_c2_ctl", 32'(ctl), 32'(C_MSWT));
        tick();
        check("mw_c3_ctl", 32'(ctl), 32'(C_MSWT));
        tick();
        bus.dmem_ready = 1'b1;
        #1;
        check("mw_done_ctl", 32'(ctl), 32'(C_BRWT));
        check("mw_cnt", 32'(bus.stall_cycles), 32'd4);
        tick();
        clear_inputs();
        #1;
        check("mw_after_ctl", 32'(ctl), 32'(C_NORM));
        check("mw_err", 32'(bus.mem_err), 32'd0);
        check("mw_cnt2", 32'(bus.stall_cycles), 32'd4);

        // Watchdog: TIMEOUT=4, ready never arrives
        bus.mem_req = 1'b1;
        #1;
        check("to_c1_ctl", 32'(ctl), 32'(C_MSRUN));
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("to_wait%0d_ctl", i), 32'(ctl), 32'(C_MSWT));
        end
        tick();
        check("to_abort_ctl", 32'(ctl), 32'(C_DNWT));
        check("to_abort_err", 32'(bus.mem_err), 32'd0);
        tick();
        check("to_err", 32'(bus.mem_err), 32'd1);
        check("to_cnt", 32'(bus.stall_cycles), 32'd8);
        bus.mem_req = 1'b0;
        #1;
        check("to_run_ctl", 32'(ctl), 32'(C_NORM));
        tick();
        check("to_err_sticky", 32'(bus.mem_err), 32'd1);

        // Stall counter saturates at all-ones
        set_load_use(5'd3);
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        check("sat_cnt", 32'(bus.stall_cycles), 32'd15);
        clear_inputs();

        // Reset during MEM_WAIT
        bus.mem_req = 1'b1;
        tick();
        check("rw_wait_ctl", 32'(ctl), 32'(C_MSWT));
        #1;
        reset = 1'b1;
        #1;
        check("rw_rst_ctl", 32'(ctl), 32'(C_ZERO));
        check("rw_rst_err", 32'(bus.mem_err), 32'd0);
        check("rw_rst_cnt", 32'(bus.stall_cycles), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("rw_rel_ctl", 32'(ctl), 32'(C_MSRUN));
        bus.mem_req = 1'b0;
        #1;
        check("rw_idle_ctl", 32'(ctl), 32'(C_NORM));
        tick();
        check("rw_err", 32'(bus.mem_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
